// File: rtl/quad_pos_decoder.sv
// rtl/quad_pos_decoder.sv - quadrature decoder with glitch filter, position counter and activity flag
module quad_pos_decoder #(
  parameter int POS_W       = 8,
  parameter int FILT_CYCLES = 3,
  parameter int IDLE_CYCLES = 1200000,
  parameter int SATURATE    = 1
) (
  input  logic             clk_12,
  input  logic             Reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [POS_W-1:0] preset,
  output logic [POS_W-1:0] position,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             active
);
  localparam int               IDLE_W   = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
  localparam logic [POS_W-1:0]  POS_RST  = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0]  POS_MAX  = '1;
  localparam logic [3:0]        FILT_N   = 4'(FILT_CYCLES);

  logic              r_a_meta;
  logic              r_b_meta;
  logic [1:0]        r_s;
  logic [1:0]        r_s_prev;
  logic [1:0]        r_f;
  logic [3:0]        r_cnt;
  logic              r_primed;
  logic [POS_W-1:0]  r_position;
  logic              r_step;
  logic              r_dir;
  logic              r_err;
  logic [IDLE_W-1:0] r_idle;
  logic              r_active;

  logic              w_pending;
  logic [3:0]        w_cnt_next;
  logic              w_commit;
  logic [1:0]        w_old_idx;
  logic [1:0]        w_new_idx;
  logic [1:0]        w_delta;
  logic              w_up;
  logic              w_down;
  logic              w_illegal;
  logic              w_valid_step;
  logic [POS_W-1:0]  w_pos_stepped;
  logic [IDLE_W-1:0] w_idle_inc;

  always_ff @(posedge clk_12 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a_meta <= 1'b0;
      r_b_meta <= 1'b0;
      r_s      <= 2'b00;
      r_s_prev <= 2'b00;
    end else begin
      r_a_meta <= enc_a;
      r_b_meta <= enc_b;
      r_s      <= {r_a_meta, r_b_meta};
      r_s_prev <= r_s;
    end
  end

  // Until primed, even a state equal to f must be confirmed, so the decoder locks onto whatever is present.
  assign w_pending  = (r_s != r_f) || !r_primed;
  assign w_cnt_next = (r_s != r_s_prev) ? 4'd1 : r_cnt + 4'd1;
  assign w_commit   = w_pending && (w_cnt_next >= FILT_N);

  // Map {A,B} onto a 0..3 ring in the up direction: 00,10,11,01.
  assign w_old_idx     = {r_f[0], r_f[1] ^ r_f[0]};
  assign w_new_idx     = {r_s[0], r_s[1] ^ r_s[0]};
  assign w_delta       = w_new_idx - w_old_idx;
  assign w_up          = (w_delta == 2'd1);
  assign w_down        = (w_delta == 2'd3);
  assign w_illegal     = (w_delta == 2'd2);
  assign w_valid_step  = w_commit && r_primed && (w_up || w_down);
  assign w_idle_inc    = r_idle + IDLE_W'(1);

  always_comb begin
    w_pos_stepped = r_position;
    if (w_up) begin
      if (!((SATURATE != 0) && (r_position == POS_MAX))) w_pos_stepped = r_position + POS_W'(1);
    end else if (w_down) begin
      if (!((SATURATE != 0) && (r_position == '0))) w_pos_stepped = r_position - POS_W'(1);
    end
  end

  always_ff @(posedge clk_12 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_f      <= 2'b00;
      r_cnt    <= 4'd0;
      r_primed <= 1'b0;
    end else if (w_commit) begin
      r_f      <= r_s;
      r_cnt    <= 4'd0;
      r_primed <= 1'b1;
    end else if (!w_pending) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk_12 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_position <= POS_RST;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_err  <= w_commit && r_primed && w_illegal;
      if (load) begin
        r_position <= preset;
      end else if (w_valid_step) begin
        r_position <= w_pos_stepped;
        r_step     <= 1'b1;
      end
      if (w_valid_step) r_dir <= w_up;
    end
  end

  always_ff @(posedge clk_12 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_idle   <= '0;
      r_active <= 1'b0;
    end else if (w_valid_step) begin
      r_idle   <= '0;
      r_active <= 1'b1;
    end else if (r_idle != IDLE_MAX) begin
      r_idle <= w_idle_inc;
      if (w_idle_inc == IDLE_MAX) r_active <= 1'b0;
    end
  end

  assign position = r_position;
  assign step     = r_step;
  assign dir      = r_dir;
  assign err      = r_err;
  assign active   = r_active;
endmodule

// File: tb/tb_quad_pos_decoder.sv
// tb/tb_quad_pos_decoder.sv - scoreboard bench for quad_pos_decoder in saturating and wrapping builds
module tb_quad_pos_decoder;
  localparam int IDLE = 40;

  typedef struct {
    int         due;
    bit         is_err;
    bit         dir;
    logic [7:0] ps;
    logic [7:0] pw;
  } exp_t;

  logic       clk_12;
  logic       Reset_n;
  logic       enc_a;
  logic       enc_b;
  logic       load;
  logic [7:0] preset;
  logic [7:0] s_pos, w_pos;
  logic       s_step, s_dir, s_err, s_act;
  logic       w_step, w_dir, w_err, w_act;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  logic [1:0] cur;
  bit         m_dir;
  logic [7:0] m_ps, m_pw;
  int         t_mark;

  quad_pos_decoder #(.POS_W(8), .FILT_CYCLES(3), .IDLE_CYCLES(IDLE), .SATURATE(1)) u_sat (
    .clk_12(clk_12), .Reset_n(Reset_n), .enc_a(enc_a), .enc_b(enc_b), .load(load), .preset(preset),
    .position(s_pos), .step(s_step), .dir(s_dir), .err(s_err), .active(s_act)
  );

  quad_pos_decoder #(.POS_W(8), .FILT_CYCLES(3), .IDLE_CYCLES(IDLE), .SATURATE(0)) u_wrap (
    .clk_12(clk_12), .Reset_n(Reset_n), .enc_a(enc_a), .enc_b(enc_b), .load(load), .preset(preset),
    .position(w_pos), .step(w_step), .dir(w_dir), .err(w_err), .active(w_act)
  );

  initial clk_12 = 1'b0;
  always #5 clk_12 = ~clk_12;
  always @(posedge clk_12) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12);
    #1;
  endtask

  function automatic int gray_delta(input logic [1:0] o, input logic [1:0] n);
    logic [3:0] k;
    k = {o, n};
    case (k)
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return -1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int d);
    int v;
    v = int'(m_ps) + d;
    if (v > 255) v = 255;
    if (v < 0) v = 0;
    m_ps = 8'(v);
    m_pw = 8'(int'(m_pw) + d);
    m_dir = (d > 0);
  endtask

  task automatic move(input logic [1:0] nxt, input int hold);
    exp_t e;
    int   d;
    d = gray_delta(cur, nxt);
    enc_a = nxt[1];
    enc_b = nxt[0];
    if (d != 0) model_step(d);
    e.due    = cyc + 5;
    e.is_err = (d == 0);
    e.dir    = m_dir;
    e.ps     = m_ps;
    e.pw     = m_pw;
    sb.push_back(e);
    cur = nxt;
    repeat (hold) tick();
  endtask

  always @(negedge clk_12) begin
    if (Reset_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missed_output_due", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (s_step || s_err || w_step || w_err) begin
        chk("output_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("latency", cyc, mon_e.due);
          chk("sat_step", s_step, !mon_e.is_err);
          chk("sat_err", s_err, mon_e.is_err);
          chk("wrap_step", w_step, !mon_e.is_err);
          chk("wrap_err", w_err, mon_e.is_err);
          chk("sat_dir", s_dir, mon_e.dir);
          chk("sat_pos", s_pos, mon_e.ps);
          chk("wrap_pos", w_pos, mon_e.pw);
        end
      end
    end
  end

  initial begin
    Reset_n = 1'b0;
    enc_a   = 1'b0;
    enc_b   = 1'b0;
    load    = 1'b0;
    preset  = 8'h00;
    cur     = 2'b00;
    m_dir   = 1'b0;
    m_ps    = 8'h80;
    m_pw    = 8'h80;
    repeat (3) tick();
    chk("rst_pos_sat", s_pos, 8'h80);
    chk("rst_pos_wrap", w_pos, 8'h80);
    chk("rst_step", s_step, 1'b0);
    chk("rst_dir", s_dir, 1'b0);
    chk("rst_err", s_err, 1'b0);
    chk("rst_active", s_act, 1'b0);

    // Release while idle at 00; the first commit only primes.
    Reset_n = 1'b1;
    repeat (10) tick();
    chk("primed_no_move", s_pos, 8'h80);

    move(2'b10, 10);
    move(2'b11, 10);
    move(2'b01, 10);
    move(2'b00, 10);
    chk("t1_pos", s_pos, 8'h84);
    chk("t1_dir", s_dir, 1'b1);

    // Two-clock glitch must be rejected; three-clock pulse counts up then down.
    enc_a = 1'b1;
    repeat (2) tick();
    enc_a = 1'b0;
    repeat (10) tick();
    chk("t2_glitch_pos", s_pos, 8'h84);
    move(2'b10, 3);
    move(2'b00, 10);
    chk("t2_pos", s_pos, 8'h84);
    chk("t2_dir", s_dir, 1'b0);

    preset = 8'hFE;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    tick();
    m_ps = 8'hFE;
    m_pw = 8'hFE;
    chk("t3_load_sat", s_pos, 8'hFE);
    chk("t3_load_wrap", w_pos, 8'hFE);
    for (int i = 0; i < 2; i++) begin
      move(2'b10, 10);
      move(2'b11, 10);
      move(2'b01, 10);
      move(2'b00, 10);
    end
    chk("t3_sat_pos", s_pos, 8'hFF);
    chk("t3_wrap_pos", w_pos, 8'h06);

    move(2'b11, 10);
    chk("t4_err_pos", w_pos, 8'h06);
    move(2'b01, 10);
    chk("t4_up_wrap", w_pos, 8'h07);
    chk("t4_up_dir", s_dir, 1'b1);

    // Down step 01->11 commits exactly on the fifth edge; load is held across it.
    enc_a = 1'b1;
    enc_b = 1'b1;
    cur   = 2'b11;
    repeat (4) tick();
    preset = 8'h10;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    m_ps   = 8'h10;
    m_pw   = 8'h10;
    m_dir  = 1'b0;
    chk("t5_pos_sat", s_pos, 8'h10);
    chk("t5_pos_wrap", w_pos, 8'h10);
    chk("t5_step", s_step, 1'b0);
    chk("t5_dir", s_dir, 1'b0);
    repeat (10) tick();

    repeat (45) tick();
    chk("t6_idle_low", s_act, 1'b0);
    move(2'b10, 5);
    chk("t6_rise", s_act, 1'b1);
    t_mark = cyc;
    repeat (IDLE - 1) tick();
    chk("t6_still_high", s_act, 1'b1);
    tick();
    chk("t6_fall_cycle", cyc - t_mark, IDLE);
    chk("t6_fall", s_act, 1'b0);

    move(2'b11, 5);
    chk("t6_pre_rst_pos", s_pos, 8'h10);
    repeat (3) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_pos_sat", s_pos, 8'h80);
    chk("async_rst_pos_wrap", w_pos, 8'h80);
    chk("async_rst_dir", s_dir, 1'b0);
    chk("async_rst_active", s_act, 1'b0);
    chk("async_rst_step", s_step, 1'b0);
    chk("async_rst_err", s_err, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
